burst_write_fsm: RTL and testbench
==================================

# burst_write_fsm

- Write-side companion to the FIFO read counter FSM.
- On a start request, issues a burst of exactly COUNTER_LEN write strobes into the FIFO, each with an incrementing data word.
- Honours the FIFO `full` backpressure and reports burst position and completion.
- Sits between the stimulus/control logic and the FIFO write port.

## Interface

Parameters:

- COUNTER_LEN, 8, words per burst; must be ≥ 2.
- DATA_W, 8, width of the write data word.

Ports:

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  burst start request; level, sampled only in IDLE.
- full  in  1  FIFO full flag; same clock domain.
- write  out  1  FIFO write strobe; one word accepted per cycle when high.
- wdata  out  DATA_W  data presented with `write`.
- counter_out  out  $clog2(COUNTER_LEN)  index of the current word in the burst (0..COUNTER_LEN-1).
- busy  out  1  high in BURST and DONE.
- done  out  1  one-cycle pulse after the last write of a burst.

## Operation

- States:
  - IDLE: `en` = 1 at a clk edge → BURST.
  - BURST: write the current word, or stall on `full`. When `write` is high and `counter_out` = COUNTER_LEN-1 → DONE.
  - DONE: always → IDLE after one cycle.
- `write` is combinational: (state == BURST) && !full. No other term.
- When `write` is high at a clk edge:
  - `counter_out` increments.
  - `wdata` increments by 1, modulo 2^DATA_W.
- `counter_out` returns to 0 on the BURST → DONE transition.
- `wdata` is NOT cleared between bursts. It forms one continuous sequence across bursts and wraps from 2^DATA_W-1 to 0.
- `full` high in BURST: `write` = 0, and counter, data and state all hold. There is no timeout.
- `en` is ignored in BURST and DONE. Holding `en` high yields repeated bursts.
- A level on `en` does not queue: a request that drops before IDLE is lost.
- Reset (`rst` = 0, any time, including mid-burst), applied immediately and without a clock:
  - state = IDLE
  - write = 0, wdata = 0, counter_out = 0, busy = 0, done = 0
- A burst aborted by reset is not resumed.

## Timing

- Latency: `en` sampled high at edge k gives BURST from edge k; the first `write` is possible in the cycle after edge k.
- With no backpressure, a burst is COUNTER_LEN consecutive `write` cycles, then 1 DONE cycle, then at least 1 IDLE cycle.
- Minimum burst-start period is COUNTER_LEN+2 cycles.
- `done` is high for exactly one cycle, the cycle after the last `write`.
- `busy` rises the cycle after `en` is sampled and falls when DONE exits.
- `full` asserted in the same cycle as the last word suppresses that write. The DONE transition waits for the actual write.
- Reset release: first `en` sampling at the first clk edge with `rst` = 1.

## Structure

- Shared FIFO package:
  - `state_t` enum (IDLE, BURST, DONE), shared with the read-side FSM.
  - Helper constant for counter width, $clog2(COUNTER_LEN).
- One sub-module: `mod_counter`, a parameterised wrap-around up-counter with enable and async active-low clear.
  - Instantiated twice: burst index (modulus COUNTER_LEN) and data sequence (modulus 2^DATA_W).
- FSM and output logic stay in the top module.

## Test plan

- Single burst, `full` = 0, `en` pulsed for 1 cycle → 8 consecutive `write` cycles with `wdata` 0..7 and `counter_out` 0..7; `done` one cycle later; `busy` low after DONE.
- Backpressure: `full` = 1 for cycles 3–5 of the burst → `write` low for exactly those 3 cycles; `wdata` holds at 3; burst completes 3 cycles late with `wdata` 0..7 intact.
- `en` held high for 3 bursts → `wdata` 0..23 continuous; bursts separated by exactly 2 non-write cycles; `done` pulses 3 times.
- Wrap (DATA_W = 4, COUNTER_LEN = 8) → after 2 bursts, the third burst's `wdata` reads 0..7 again (15 → 0 wrap verified).
- Reset mid-burst after 4 writes → all outputs 0 immediately without a clock edge; next `en` starts a burst at `wdata` = 0, `counter_out` = 0.
- `full` high on the last word, released 2 cycles later → `done` is not asserted until the cycle after the delayed 8th write.

Source files
------------

// File: rtl/burst_write_fsm_pkg.sv
// Shared FIFO control package: state encoding common to the read- and write-side
// FSMs, default sizes and the burst-index width helper.
package burst_write_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned COUNTER_LEN_DEF = 8;
  localparam int unsigned DATA_W_DEF      = 8;

  // Index width for a burst of len words; a single-bit floor keeps the port legal.
  function automatic int unsigned cnt_w(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/burst_write_fsm_mod_counter.sv
// Wrap-around up-counter: counts 0..MODULUS-1 while enabled, cleared asynchronously.
module mod_counter #(
  parameter int unsigned     WIDTH   = 8,
  parameter longint unsigned MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= (r_q == LAST) ? '0 : r_q + WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/burst_write_fsm.sv
// FIFO write-side burst engine: on a start request writes COUNTER_LEN words of a
// continuous incrementing data sequence, stalling on full, then pulses done.
module burst_write_fsm
  import burst_write_fsm_pkg::*;
#(
  parameter int unsigned COUNTER_LEN = COUNTER_LEN_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            full,
  output logic                            write,
  output logic [DATA_W-1:0]               wdata,
  output logic [cnt_w(COUNTER_LEN)-1:0]   counter_out,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned     CNT_W    = cnt_w(COUNTER_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNTER_LEN - 1);
  localparam longint unsigned DATA_MOD = 64'd1 << DATA_W;

  state_t r_state;
  logic   r_busy;
  logic   r_done;
  logic   w_write;
  logic   w_last;

  // The strobe is purely state and backpressure so a full FIFO blocks it in the same cycle.
  assign w_write = (r_state == BURST) && !full;
  assign w_last  = (counter_out == LAST_IDX);

  mod_counter #(
    .WIDTH   (CNT_W),
    .MODULUS (64'(COUNTER_LEN))
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_write),
    .o_q   (counter_out)
  );

  // Data sequence runs across bursts; only reset returns it to zero.
  mod_counter #(
    .WIDTH   (DATA_W),
    .MODULUS (DATA_MOD)
  ) u_data_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_write),
    .o_q   (wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (en) begin
            r_state <= BURST;
            r_busy  <= 1'b1;
          end
        end
        BURST: begin
          if (w_write && w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign write = w_write;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_burst_write_fsm.sv
// Scoreboarded bench for burst_write_fsm: directed scenarios plus random en/full
// traffic compared against a burst-level reference model.
module tb_burst_write_fsm;

  localparam int unsigned CL = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = $clog2(CL);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          full;
  logic          write;
  logic [DW-1:0] wdata;
  logic [CW-1:0] counter_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  burst_write_fsm #(
    .COUNTER_LEN (CL),
    .DATA_W      (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .full        (full),
    .write       (write),
    .wdata       (wdata),
    .counter_out (counter_out),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    bit write;
    bit busy;
    bit done;
    int cnt;
    int wd;
  } ctl_t;

  typedef struct {
    int wd;
    int idx;
  } word_t;

  ctl_t  ctl_q[$];
  word_t data_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words still owed in the current burst, done cycle flag,
  // and total words written since reset.
  int m_left;
  bit m_done;
  int m_seq;
  bit en_d;
  bit full_d;
  bit end_req = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (!full_d) begin
        m_seq++;
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end
    end else if (en_d) begin
      m_left = CL;
      for (int i = 0; i < CL; i++)
        data_q.push_back('{wd: (m_seq + i) % (1 << DW), idx: i});
    end
  endfunction

  function automatic void push_exp();
    ctl_t e;
    e.write = (m_left > 0) && !full_d;
    e.busy  = (m_left > 0) || m_done;
    e.done  = m_done;
    e.cnt   = (m_left > 0) ? (CL - m_left) : 0;
    e.wd    = m_seq % (1 << DW);
    ctl_q.push_back(e);
  endfunction

  task automatic cycle(input bit e_v, input bit f_v);
    @(posedge clk);
    #1;
    model_edge();
    en     = e_v;
    full   = f_v;
    en_d   = e_v;
    full_d = f_v;
    push_exp();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic reset_now();
    @(negedge clk);
    #1;
    rst  = 1'b0;
    en   = 1'b0;
    full = 1'b0;
    #2;
    ctl_q.delete();
    data_q.delete();
    m_left = 0;
    m_done = 1'b0;
    m_seq  = 0;
    en_d   = 1'b0;
    full_d = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp();
  endtask

  // Monitor: reset values on any reset, otherwise per-cycle control and word checks.
  initial begin
    ctl_t  e;
    word_t w;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        #1;
        chk("rst_write", int'(write), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_counter", int'(counter_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
      end else begin
        if (ctl_q.size() > 0) begin
          e = ctl_q.pop_front();
          chk("write", int'(write), int'(e.write));
          chk("busy", int'(busy), int'(e.busy));
          chk("done", int'(done), int'(e.done));
          chk("counter_out", int'(counter_out), e.cnt);
          chk("wdata", int'(wdata), e.wd);
          if (write) begin
            if (data_q.size() == 0) begin
              chk("unexpected_write", 1, 0);
            end else begin
              w = data_q.pop_front();
              chk("word_data", int'(wdata), w.wd);
              chk("word_index", int'(counter_out), w.idx);
            end
          end
        end
        if (end_req) begin
          chk("words_outstanding", data_q.size(), 0);
          end_req = 1'b0;
        end
      end
    end
  end

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    full   = 1'b0;
    en_d   = 1'b0;
    full_d = 1'b0;
    m_left = 0;
    m_done = 1'b0;
    m_seq  = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp();

    // Single burst from a one-cycle request
    cycle(1'b1, 1'b0);
    idle(12);

    // Backpressure on burst words 3..5
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    idle(10);

    // Held request: three back-to-back bursts, data wraps
    for (int i = 0; i < 3 * (CL + 2); i++) cycle(1'b1, 1'b0);
    idle(4);

    // Full on the last word, released two cycles later
    cycle(1'b1, 1'b0);
    for (int i = 0; i < CL - 1; i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    idle(6);

    // Reset after four writes, then a fresh burst
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
    reset_now();
    cycle(1'b1, 1'b0);
    idle(12);

    // Random request and backpressure traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));

    // Occasional reset during random traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'($urandom_range(3, 20)); i++)
        cycle(1'b1, 1'($urandom_range(0, 5) == 0));
      reset_now();
    end

    idle(2 * CL);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
